// File: rtl/picorv_mem_bridge_pkg.sv
// Shared types and constants for the picorv32 memory bridge.
// Covers the FSM state encoding, UART window offsets and STATUS bit positions.
package picorv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_RSP = 2'd1,
    TX_WAIT = 2'd2,
    RSP     = 2'd3
  } state_e;

  localparam logic [31:0] UART_TXDATA  = 32'h0000_0000;
  localparam logic [31:0] UART_RXDATA  = 32'h0000_0004;
  localparam logic [31:0] UART_STATUS  = 32'h0000_0008;
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  localparam int STATUS_TX_READY = 0;
  localparam int STATUS_RX_VALID = 1;
  localparam int STATUS_BUS_ERR  = 2;

endpackage

// File: rtl/picorv_mem_bridge_if.sv
// Bundles the CPU native bus, the sync RAM port and the UART TX/RX handshakes.
// The slave modport is the bridge; the master modport is the surrounding CPU/RAM/UART.
interface picorv_mem_bridge_if #(
  parameter int RamWords = 256
);
  localparam int AW = $clog2(RamWords);

  logic          mem_valid_i;
  logic          mem_instr_i;
  logic [31:0]   mem_addr_i;
  logic [31:0]   mem_wdata_i;
  logic [3:0]    mem_wstrb_i;
  logic          mem_ready_o;
  logic [31:0]   mem_rdata_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0]    ram_wr_en_o;
  logic [31:0]   ram_wr_data_o;
  logic [31:0]   ram_rd_data_i;
  logic [7:0]    tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          rx_ready_o;
  logic          bus_err_o;

  modport master (
    output mem_valid_i, mem_instr_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
           ram_rd_data_i, tx_ready_i, rx_data_i, rx_valid_i,
    input  mem_ready_o, mem_rdata_o, ram_addr_o, ram_wr_en_o, ram_wr_data_o,
           tx_data_o, tx_valid_o, rx_ready_o, bus_err_o
  );

  modport slave (
    input  mem_valid_i, mem_instr_i, mem_addr_i, mem_wdata_i, mem_wstrb_i,
           ram_rd_data_i, tx_ready_i, rx_data_i, rx_valid_i,
    output mem_ready_o, mem_rdata_o, ram_addr_o, ram_wr_en_o, ram_wr_data_o,
           tx_data_o, tx_valid_o, rx_ready_o, bus_err_o
  );

endinterface

// File: rtl/picorv_mem_bridge.sv
// Bridges the picorv32 native memory bus to a sync-read RAM and a three-word UART window.
// Unmapped accesses and TX timeouts raise a sticky error that software clears through STATUS.
module picorv_mem_bridge
  import picorv_bus_pkg::*;
#(
  parameter int          RamWords      = 256,
  parameter logic [31:0] UartBase      = 32'h1000_0000,
  parameter int          TimeoutCycles = 16
) (
  input logic                 clk_i,
  input logic                 reset_i,
  picorv_mem_bridge_if.slave  bus
);

  localparam int          AW        = $clog2(RamWords);
  localparam int          CW        = $clog2(TimeoutCycles) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RamWords * 4);
  localparam logic [CW-1:0] TX_LAST = CW'(TimeoutCycles - 1);

  state_e        state, state_next;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    tx_data;
  logic          tx_load;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic          bus_err, err_set, err_clr;

  logic [31:0]   word_addr, uart_off;
  logic          ram_hit, is_tx, is_rx, is_status, is_write;

  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wr_en;
  logic          rx_ready, tx_valid;
  logic [31:0]   status_word;

  logic          unused_bits;
  assign unused_bits = ^{bus.mem_instr_i, bus.mem_addr_i[1:0]};

  // RAM takes priority so a UART base placed inside RAM cannot shadow memory.
  assign word_addr = {bus.mem_addr_i[31:2], 2'b00};
  assign uart_off  = word_addr - UartBase;
  assign ram_hit   = word_addr < RAM_BYTES;
  assign is_tx     = !ram_hit && (uart_off == UART_TXDATA);
  assign is_rx     = !ram_hit && (uart_off == UART_RXDATA);
  assign is_status = !ram_hit && (uart_off == UART_STATUS);
  assign is_write  = |bus.mem_wstrb_i;

  always_comb begin
    status_word                  = '0;
    status_word[STATUS_TX_READY] = bus.tx_ready_i;
    status_word[STATUS_RX_VALID] = bus.rx_valid_i;
    status_word[STATUS_BUS_ERR]  = bus_err;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= IDLE;
      rdata_q <= '0;
      tx_data <= '0;
      tx_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_next;
      rdata_q <= rdata_d;
      tx_cnt  <= tx_cnt_d;
      if (tx_load) tx_data <= bus.mem_wdata_i[7:0];
      if (err_set)      bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    rdata_d    = rdata_q;
    tx_load    = 1'b0;
    tx_cnt_d   = tx_cnt;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    ram_addr   = '0;
    ram_wr_en  = '0;
    rx_ready   = 1'b0;
    tx_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_valid_i) begin
          state_next = RSP;
          rdata_d    = '0;
          if (ram_hit) begin
            ram_addr   = bus.mem_addr_i[AW+1:2];
            ram_wr_en  = bus.mem_wstrb_i;
            state_next = RAM_RSP;
          end else if (is_tx) begin
            if (bus.mem_wstrb_i[0]) begin
              tx_load    = 1'b1;
              tx_cnt_d   = '0;
              state_next = TX_WAIT;
            end
          end else if (is_rx) begin
            if (!is_write) begin
              rdata_d  = {bus.rx_valid_i, 23'b0, bus.rx_data_i};
              rx_ready = bus.rx_valid_i;
            end
          end else if (is_status) begin
            if (is_write) err_clr = bus.mem_wdata_i[STATUS_BUS_ERR];
            else          rdata_d = status_word;
          end else begin
            rdata_d = BUS_ERR_DATA;
            err_set = 1'b1;
          end
        end
      end
      RAM_RSP: begin
        mem_ready  = 1'b1;
        mem_rdata  = bus.ram_rd_data_i;
        state_next = IDLE;
      end
      // A handshake on the final allowed cycle still counts as delivered.
      TX_WAIT: begin
        tx_valid = 1'b1;
        if (bus.tx_ready_i) begin
          state_next = RSP;
        end else if (tx_cnt == TX_LAST) begin
          err_set    = 1'b1;
          state_next = RSP;
        end else begin
          tx_cnt_d = tx_cnt + 1'b1;
        end
      end
      RSP: begin
        mem_ready  = 1'b1;
        mem_rdata  = rdata_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_ready_o   = mem_ready;
  assign bus.mem_rdata_o   = mem_rdata;
  assign bus.ram_addr_o    = ram_addr;
  assign bus.ram_wr_en_o   = ram_wr_en;
  assign bus.ram_wr_data_o = bus.mem_wdata_i;
  assign bus.tx_data_o     = tx_data;
  assign bus.tx_valid_o    = tx_valid;
  assign bus.rx_ready_o    = rx_ready;
  assign bus.bus_err_o     = bus_err;

endmodule

// File: tb/tb_picorv_mem_bridge.sv
// Directed bench for picorv_mem_bridge with a behavioural sync RAM.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_picorv_mem_bridge;

  localparam logic [31:0] UART = 32'h1000_0000;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   txReadyCycle;
  int   txvCount;
  int   rxrCount;
  int   lat;
  int   readyCount;
  logic [31:0] rd;
  logic [3:0]  wrEnFirst;
  logic [3:0]  wrEnSecond;
  logic [7:0]  addrFirst;
  logic [31:0] ramArray [256];

  picorv_mem_bridge_if #(.RamWords(256)) bus ();

  picorv_mem_bridge #(
    .RamWords(256),
    .UartBase(UART),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk),
    .reset_i(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read RAM: data for the address seen at an edge appears after that edge.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.ram_wr_en_o[b]) ramArray[bus.ram_addr_o][8*b +: 8] <= bus.ram_wr_data_o[8*b +: 8];
    bus.ram_rd_data_i <= ramArray[bus.ram_addr_o];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.mem_valid_i = 1'b1;
    bus.mem_addr_i  = addr;
    bus.mem_wdata_i = wdata;
    bus.mem_wstrb_i = wstrb;
  endtask

  // Waits up to 40 cycles for mem_ready; lat counts cycles after the accepting cycle.
  task automatic waitReady(output logic [31:0] rdata, output int latency);
    rdata    = '0;
    latency  = -1;
    txvCount = 0;
    rxrCount = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        wrEnFirst = bus.ram_wr_en_o;
        addrFirst = bus.ram_addr_o;
      end
      if (c == 2) wrEnSecond = bus.ram_wr_en_o;
      if (bus.tx_valid_o) txvCount++;
      if (bus.rx_ready_o) rxrCount++;
      if (bus.mem_ready_o) begin
        rdata   = bus.mem_rdata_o;
        latency = c - 1;
      end
      @(posedge clk);
      #1;
      if (latency >= 0) break;
      bus.tx_ready_i = (txReadyCycle > 0) && (c + 1 >= txReadyCycle);
    end
    bus.mem_valid_i = 1'b0;
    bus.mem_wstrb_i = '0;
    bus.tx_ready_i  = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    txReadyCycle = 0;
    rst = 1'b1;
    bus.mem_valid_i = 1'b0;
    bus.mem_instr_i = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_wdata_i = '0;
    bus.mem_wstrb_i = '0;
    bus.tx_ready_i  = 1'b0;
    bus.rx_data_i   = '0;
    bus.rx_valid_i  = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_ready", bus.mem_ready_o, 0);
    checkOutput("rst_mem_rdata", bus.mem_rdata_o, 0);
    checkOutput("rst_ram_wr_en", bus.ram_wr_en_o, 0);
    checkOutput("rst_ram_addr", bus.ram_addr_o, 0);
    checkOutput("rst_tx_data", bus.tx_data_o, 0);
    checkOutput("rst_tx_valid", bus.tx_valid_o, 0);
    checkOutput("rst_rx_ready", bus.rx_ready_o, 0);
    checkOutput("rst_bus_err", bus.bus_err_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of TX_WAIT aborts the transfer.
    applyStimulus(UART, 32'h41, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_abort_tx_valid", bus.tx_valid_o, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_valid_i = 1'b0;
    bus.mem_wstrb_i = '0;
    @(negedge clk);
    checkOutput("abort_tx_valid", bus.tx_valid_o, 0);
    checkOutput("abort_mem_ready", bus.mem_ready_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    readyCount = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_ready_o) readyCount++;
    end
    checkOutput("abort_no_ready", readyCount, 0);
    @(posedge clk);
    #1;

    // Top RAM word: full write then read.
    applyStimulus(32'h3FC, 32'h1234_5678, 4'b1111);
    waitReady(rd, lat);
    checkOutput("ram_wr_en_full", wrEnFirst, 4'b1111);
    checkOutput("ram_addr_top", addrFirst, 255);
    checkOutput("ram_wr_en_one_cycle", wrEnSecond, 0);
    checkOutput("ram_wr_latency", lat, 1);
    applyStimulus(32'h3FC, 32'h0, 4'b0000);
    waitReady(rd, lat);
    checkOutput("ram_rd_data", rd, 32'h1234_5678);
    checkOutput("ram_rd_latency", lat, 1);
    checkOutput("ram_rd_no_wr_en", wrEnFirst, 0);
    @(negedge clk);
    checkOutput("idle_rdata_zero", bus.mem_rdata_o, 0);
    @(posedge clk);
    #1;

    // Single byte lane write.
    applyStimulus(32'h3FC, 32'h0000_AB00, 4'b0010);
    waitReady(rd, lat);
    checkOutput("ram_wr_en_byte1", wrEnFirst, 4'b0010);
    applyStimulus(32'h3FC, 32'h0, 4'b0000);
    waitReady(rd, lat);
    checkOutput("ram_byte_readback", rd, 32'h1234_AB78);

    // First address past the RAM is unmapped.
    applyStimulus(32'h400, 32'hFFFF_FFFF, 4'b1111);
    waitReady(rd, lat);
    checkOutput("unmapped_wr_en", wrEnFirst, 0);
    checkOutput("unmapped_rdata", rd, 32'hDEAD_BEEF);
    checkOutput("unmapped_latency", lat, 1);
    checkOutput("unmapped_bus_err", bus.bus_err_o, 1);
    applyStimulus(UART + 32'h8, 32'h4, 4'b1111);
    waitReady(rd, lat);
    checkOutput("clear_bus_err", bus.bus_err_o, 0);

    // TX with ready arriving in the fourth TX_WAIT cycle.
    txReadyCycle = 5;
    applyStimulus(UART, 32'hFFFF_FF41, 4'b0001);
    waitReady(rd, lat);
    txReadyCycle = 0;
    checkOutput("tx_data", bus.tx_data_o, 32'h41);
    checkOutput("tx_valid_cycles", txvCount, 4);
    checkOutput("tx_latency", lat, 5);
    checkOutput("tx_rdata", rd, 0);
    checkOutput("tx_no_err", bus.bus_err_o, 0);

    // TX timeout after 16 waiting cycles.
    applyStimulus(UART, 32'h42, 4'b0001);
    waitReady(rd, lat);
    checkOutput("timeout_latency", lat, 17);
    checkOutput("timeout_tx_valid_cycles", txvCount, 16);
    checkOutput("timeout_bus_err", bus.bus_err_o, 1);
    @(negedge clk);
    checkOutput("timeout_tx_valid_low", bus.tx_valid_o, 0);
    @(posedge clk);
    #1;
    applyStimulus(UART + 32'h8, 32'h0, 4'b0000);
    waitReady(rd, lat);
    checkOutput("status_err_bit", rd, 32'h4);
    applyStimulus(UART + 32'h8, 32'h4, 4'b0001);
    waitReady(rd, lat);
    checkOutput("status_clear", bus.bus_err_o, 0);

    // TXDATA write without byte 0 and TXDATA read have no side effect.
    applyStimulus(UART, 32'h0000_5500, 4'b0010);
    waitReady(rd, lat);
    checkOutput("tx_nolane_latency", lat, 1);
    checkOutput("tx_nolane_valid", txvCount, 0);
    checkOutput("tx_nolane_data", bus.tx_data_o, 32'h42);
    applyStimulus(UART, 32'h0, 4'b0000);
    waitReady(rd, lat);
    checkOutput("tx_read_zero", rd, 0);

    // Unmapped read, then STATUS showing all three flags.
    applyStimulus(32'h2000_0000, 32'h0, 4'b0000);
    waitReady(rd, lat);
    checkOutput("unmapped_rd", rd, 32'hDEAD_BEEF);
    checkOutput("unmapped_rd_err", bus.bus_err_o, 1);
    bus.tx_ready_i = 1'b1;
    bus.rx_valid_i = 1'b1;
    txReadyCycle   = 1;
    applyStimulus(UART + 32'h8, 32'h0, 4'b0000);
    waitReady(rd, lat);
    txReadyCycle = 0;
    checkOutput("status_all", rd, 32'h7);
    applyStimulus(UART + 32'h8, 32'h4, 4'b1111);
    waitReady(rd, lat);
    checkOutput("status_clear2", bus.bus_err_o, 0);

    // RX reads with and without a pending byte.
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 8'h5A;
    applyStimulus(UART + 32'h4, 32'h0, 4'b0000);
    waitReady(rd, lat);
    checkOutput("rx_rdata", rd, 32'h8000_005A);
    checkOutput("rx_pop_count", rxrCount, 1);
    bus.rx_valid_i = 1'b0;
    applyStimulus(UART + 32'h4, 32'h0, 4'b0000);
    waitReady(rd, lat);
    checkOutput("rx_empty_rdata", rd, 32'h0000_005A);
    checkOutput("rx_empty_no_pop", rxrCount, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
